// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and
// default sizing for requesters, packet length and the downstream UART.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEFAULT       = 4;
  localparam int MAX_PKT_LEN_DEFAULT = 32;
  localparam int CLK_FREQ            = 27;
  localparam int BAUD_RATE           = 115200;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: returns one-hot the first set request bit at or
// after ptr, wrapping modulo N_REQ. Purely combinational.
module rr_priority_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding bytes from N_REQ requesters into
// a single uart_tx byte port; a grant is held for a whole packet.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEFAULT,
  parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_data_valid,
  input  logic               tx_data_ready,
  output logic               busy,
  output logic               trunc_err
);

  // Handshakes: a byte moves on either side only at a rising edge where the
  // matching valid and ready are both 1; valid never waits on ready.

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  arb_state_t       state;
  logic [N_REQ-1:0] pick;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] next_ptr;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic             tx_free;
  logic             req_fire;
  logic             tx_fire;
  logic             at_limit;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // Grant is one-hot, so a priority-free mux over it selects the owner.
  always_comb begin
    owner    = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        owner    = PTR_W'(i);
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  assign next_ptr  = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
  assign tx_free   = !tx_data_valid || tx_data_ready;
  assign req_ready = (state == LOCK && tx_free) ? grant : '0;
  assign req_fire  = |(req_valid & req_ready);
  assign tx_fire   = tx_data_valid && tx_data_ready;
  assign at_limit  = (byte_cnt == CNT_W'(MAX_PKT_LEN - 1));
  assign busy      = (state != IDLE) || tx_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      byte_cnt      <= '0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      trunc_err     <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= pick;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (req_fire) begin
            tx_data       <= sel_data;
            tx_data_valid <= 1'b1;
            byte_cnt      <= byte_cnt + 1'b1;
            // The byte filling the packet limit closes the packet like a last.
            if (sel_last || at_limit) begin
              state     <= DRAIN;
              trunc_err <= !sel_last;
            end
          end else if (tx_fire) begin
            tx_data_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (tx_fire) begin
            tx_data_valid <= 1'b0;
            grant         <= '0;
            rr_ptr        <= next_ptr;
            byte_cnt      <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester drivers, a negedge monitor
// with an expected {owner, byte} queue, and a final summary.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 10;
  localparam int DEPTH = 64;

  logic           clk;
  logic           rst_n;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_data_valid;
  logic           tx_data_ready;
  logic           busy;
  logic           trunc_err;

  uart_tx_arbiter #(.N_REQ(N), .MAX_PKT_LEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .busy          (busy),
    .trunc_err     (trunc_err)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   exp_q[$];
  logic [7:0]     rq_mem   [N][DEPTH];
  bit             rq_lastm [N][DEPTH];
  int             rq_wr [N];
  int             rq_rd [N];
  bit             hold  [N];
  logic [N-1:0]   take;
  int             rx_count = 0;
  int             trunc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [N-1:0] g);
    enc = '0;
    for (int i = 0; i < N; i++) if (g[i]) enc = 2'(i);
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq_rd[i] < rq_wr[i] && !hold[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Driver tasks
  task automatic enqueue(input int r, input logic [7:0] b, input bit last, input bit expect_out);
    rq_mem[r][rq_wr[r]]   = b;
    rq_lastm[r][rq_wr[r]] = last;
    rq_wr[r]++;
    if (expect_out) exp_q.push_back({2'(r), b});
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      rq_wr[i] = 0;
      rq_rd[i] = 0;
      hold[i]  = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tx_data_ready = 1'b1;
    clear_queues();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input bit need_idle, input int budget);
    int n;
    n = 0;
    while (n < budget && (exp_q.size() != 0 || (need_idle && (busy || pending())))) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(n < budget), 1);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rx(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && rx_count < target) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(n < budget), 1);
  endtask

  // Requester model: presents the head of each per-requester queue.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (take[i]) rq_rd[i]++;
        req_valid[i]        = (rq_rd[i] < rq_wr[i]) && !hold[i];
        req_data[8*i +: 8]  = (rq_rd[i] < rq_wr[i]) ? rq_mem[i][rq_rd[i]] : 8'h00;
        req_last[i]         = (rq_rd[i] < rq_wr[i]) ? rq_lastm[i][rq_rd[i]] : 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [7:0]   prev_data;
    bit           prev_stall;
    logic [W-1:0] e;
    prev_data  = '0;
    prev_stall = 1'b0;
    take       = '0;
    forever begin
      @(negedge clk);
      take = req_valid & req_ready;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("req_ready_onehot", 32'($countones(req_ready) <= 1), 1);
        if (prev_stall) begin
          check("tx_hold_valid", 32'(tx_data_valid), 1);
          check("tx_hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_data_valid && tx_data_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got owner %0d byte %0h expected nothing", enc(grant), tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'({enc(grant), tx_data}), 32'(e));
          end
          rx_count++;
        end
        if (trunc_err) trunc_cnt++;
        prev_stall = tx_data_valid && !tx_data_ready;
        prev_data  = tx_data;
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed scenarios
  initial begin
    int         base;
    int         n;
    int         bad;
    int         tc;
    logic [7:0] cb [16];

    rst_n = 1'b0;
    tx_data_ready = 1'b1;
    clear_queues();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_valid", 32'(tx_data_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_trunc", 32'(trunc_err), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Single packet "Hi\r\n" from req0
    enqueue(0, 8'h48, 1'b0, 1'b1);
    enqueue(0, 8'h69, 1'b0, 1'b1);
    enqueue(0, 8'h0D, 1'b0, 1'b1);
    enqueue(0, 8'h0A, 1'b1, 1'b1);
    n = 0;
    @(negedge clk);
    while (!req_valid[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("s1_grant_t0", 32'(grant), 0);
    @(negedge clk);
    check("s1_grant_t1", 32'(grant), 32'h1);
    check("s1_ready_t1", 32'(req_ready), 32'h1);
    check("s1_txv_t1", 32'(tx_data_valid), 0);
    @(negedge clk);
    check("s1_txv_t2", 32'(tx_data_valid), 1);
    check("s1_txd_t2", 32'(tx_data), 32'h48);
    wait_drain("s1_drain", 1'b1, 50);
    check("s1_grant_idle", 32'(grant), 0);
    check("s1_rr_ptr", 32'(dut.rr_ptr), 1);

    // Contention: two 2-byte packets per requester, emission order 0,1,2,3,0,1,2,3
    reset_dut();
    cb = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1,
           8'hA2, 8'hA3, 8'hB2, 8'hB3, 8'hC2, 8'hC3, 8'hD2, 8'hD3};
    for (int k = 0; k < 16; k++) enqueue((k / 2) % 4, cb[k], bit'(k % 2), 1'b1);
    wait_drain("s2_drain", 1'b1, 200);
    check("s2_rr_ptr", 32'(dut.rr_ptr), 0);

    // Backpressure: tx_data_ready low for 50 cycles mid-packet
    reset_dut();
    cb[0] = 8'h11; cb[1] = 8'h22; cb[2] = 8'h33; cb[3] = 8'h44; cb[4] = 8'h55;
    for (int k = 0; k < 5; k++) enqueue(0, cb[k], bit'(k == 4), 1'b1);
    base = rx_count;
    wait_rx("s3_reach_mid", base + 2, 50);
    @(posedge clk);
    #2 tx_data_ready = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready != '0) bad++;
    end
    check("s3_ready_low", 32'(bad), 0);
    check("s3_txv_held", 32'(tx_data_valid), 1);
    @(posedge clk);
    #2 tx_data_ready = 1'b1;
    wait_drain("s3_drain", 1'b1, 50);
    check("s3_byte_count", 32'(rx_count - base), 5);

    // Truncation: req2 sends 40 bytes with no last, req3 waits
    reset_dut();
    tc = trunc_cnt;
    for (int k = 0; k < 32; k++) enqueue(2, 8'(64 + k), 1'b0, 1'b1);
    enqueue(3, 8'hE0, 1'b0, 1'b1);
    enqueue(3, 8'hE1, 1'b1, 1'b1);
    for (int k = 32; k < 40; k++) enqueue(2, 8'(64 + k), 1'b0, 1'b1);
    wait_drain("s4_emit", 1'b0, 300);
    check("s4_trunc_pulses", 32'(trunc_cnt - tc), 1);
    check("s4_regrant_req2", 32'(grant), 32'h4);

    // Reset mid-packet during the 3rd byte of req2's 5-byte packet
    reset_dut();
    enqueue(1, 8'h31, 1'b0, 1'b1);
    enqueue(1, 8'h32, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) enqueue(2, 8'(8'h51 + k), bit'(k == 4), bit'(k < 2));
    base = rx_count;
    wait_rx("s5_reach_mid", base + 4, 60);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5_grant", 32'(grant), 0);
    check("s5_req_ready", 32'(req_ready), 0);
    check("s5_tx_data", 32'(tx_data), 0);
    check("s5_tx_valid", 32'(tx_data_valid), 0);
    check("s5_busy", 32'(busy), 0);
    check("s5_exp_empty", 32'(exp_q.size()), 0);
    clear_queues();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    enqueue(1, 8'h81, 1'b0, 1'b1);
    enqueue(1, 8'h82, 1'b1, 1'b1);
    enqueue(3, 8'h91, 1'b0, 1'b1);
    enqueue(3, 8'h92, 1'b1, 1'b1);
    wait_drain("s5_drain", 1'b1, 60);

    // Owner stall: req1 drops valid for 10 cycles while req0 waits
    reset_dut();
    for (int k = 0; k < 4; k++) enqueue(1, 8'(8'h71 + k), bit'(k == 3), 1'b1);
    n = 0;
    @(negedge clk);
    while (grant != 4'b0010 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s6_grant_req1", 32'(grant), 32'h2);
    @(posedge clk);
    #2;
    enqueue(0, 8'h61, 1'b0, 1'b1);
    enqueue(0, 8'h62, 1'b1, 1'b1);
    hold[1] = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (grant != 4'b0010) bad++;
    end
    check("s6_grant_held", 32'(bad), 0);
    check("s6_txv_fell", 32'(tx_data_valid), 0);
    @(posedge clk);
    #2 hold[1] = 1'b0;
    wait_drain("s6_drain", 1'b1, 60);
    check("s6_rr_ptr", 32'(dut.rr_ptr), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
